// File: rtl/fetch_unit_pkg.sv
// Shared core constants and the fetch-buffer entry layout.
// Both the fetch unit and its buffer import this package.
package fetch_unit_pkg;

    localparam logic [31:0] NOP_INSTR         = 32'h0000_0013;
    localparam logic [31:0] DEFAULT_RESET_PC  = 32'h0000_0000;
    localparam int unsigned DEFAULT_BUF_DEPTH = 2;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] instr;
    } fetch_entry_t;

endpackage

// File: rtl/fetch_fifo.sv
// Fetch buffer: circular FIFO of {pc, instr} entries with flush and occupancy count.
// The head entry is always visible on head_o, even when the buffer is empty.
module fetch_fifo
    import fetch_unit_pkg::*;
#(
    parameter int unsigned DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         push_i,
    input  fetch_entry_t                 data_i,
    input  logic                         pop_i,
    input  logic                         flush_i,
    output fetch_entry_t                 head_o,
    output logic [$clog2(DEPTH+1)-1:0]   count_o
);

    localparam int unsigned PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH + 1);

    fetch_entry_t  mem_q [DEPTH];
    logic [PW-1:0] rd_q, rd_d;
    logic [PW-1:0] wr_q, wr_d;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          do_push;
    logic          do_pop;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    always_comb begin
        do_pop  = pop_i && (cnt_q != '0);
        do_push = push_i && ((cnt_q != CW'(DEPTH)) || do_pop);
        rd_d    = rd_q;
        wr_d    = wr_q;
        cnt_d   = cnt_q;
        if (flush_i) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            if (do_push) wr_d = ptr_inc(wr_q);
            if (do_pop)  rd_d = ptr_inc(rd_q);
            if (do_push && !do_pop)      cnt_d = cnt_q + CW'(1);
            else if (do_pop && !do_push) cnt_d = cnt_q - CW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_q  <= '0;
            wr_q  <= '0;
            cnt_q <= '0;
        end else begin
            rd_q  <= rd_d;
            wr_q  <= wr_d;
            cnt_q <= cnt_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < int'(DEPTH); i++) mem_q[i] <= '0;
        end else if (do_push && !flush_i) begin
            mem_q[wr_q] <= data_i;
        end
    end

    assign head_o  = mem_q[rd_q];
    assign count_o = cnt_q;

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch: PC sequencing, credit-limited memory requests, redirect
// with drop of stale responses, and a small buffer presenting the head to IF/ID.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC  = DEFAULT_RESET_PC,
    parameter int unsigned BUF_DEPTH = DEFAULT_BUF_DEPTH
) (
    input  logic        clk,
    input  logic        res,
    input  logic        write,
    input  logic        branch_taken,
    input  logic [31:0] branch_target,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_gnt,
    input  logic        imem_rvalid,
    input  logic [31:0] imem_rdata,
    output logic [31:0] PC_out,
    output logic [31:0] instruction_out,
    output logic        valid_out
);

    localparam int unsigned CW = $clog2(BUF_DEPTH + 1);
    localparam int unsigned OW = CW + 1;
    localparam int unsigned PW = (BUF_DEPTH > 1) ? $clog2(BUF_DEPTH) : 1;

    logic [31:0]   pc_q, pc_d;
    logic [CW-1:0] out_q, out_d;
    logic [CW-1:0] drop_q, drop_d;
    logic [31:0]   aq_q [BUF_DEPTH];
    logic [PW-1:0] aq_rd_q, aq_rd_d;
    logic [PW-1:0] aq_wr_q, aq_wr_d;

    fetch_entry_t  fifo_head;
    fetch_entry_t  fifo_wdata;
    logic [CW-1:0] fifo_cnt;
    logic          fifo_push;
    logic          fifo_flush;

    logic          head_valid_c;
    logic          pop_c;
    logic          rsp_c;
    logic          grant_c;
    logic [OW-1:0] occ_c;

    function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
        return (p == PW'(BUF_DEPTH - 1)) ? '0 : p + PW'(1);
    endfunction

    // A head leaving this cycle frees its slot for this cycle's request,
    // which is what sustains one instruction per cycle at BUF_DEPTH=2.
    always_comb begin
        head_valid_c = (fifo_cnt != '0);
        pop_c        = head_valid_c && write && !branch_taken;
        rsp_c        = imem_rvalid && (out_q != '0);
        occ_c        = OW'(out_q) + OW'(fifo_cnt) - OW'(pop_c);
        imem_req     = res && !branch_taken && (occ_c < OW'(BUF_DEPTH));
        grant_c      = imem_req && imem_gnt;
        imem_addr    = pc_q;
    end

    always_comb begin
        pc_d             = pc_q;
        out_d            = out_q;
        drop_d           = drop_q;
        aq_rd_d          = aq_rd_q;
        aq_wr_d          = aq_wr_q;
        fifo_push        = 1'b0;
        fifo_flush       = 1'b0;
        fifo_wdata.pc    = aq_q[aq_rd_q];
        fifo_wdata.instr = imem_rdata;

        case ({grant_c, rsp_c})
            2'b10:   out_d = out_q + CW'(1);
            2'b01:   out_d = out_q - CW'(1);
            default: out_d = out_q;
        endcase
        if (rsp_c)   aq_rd_d = ptr_inc(aq_rd_q);
        if (grant_c) aq_wr_d = ptr_inc(aq_wr_q);

        // Redirect wins: everything still in flight becomes stale.
        if (branch_taken) begin
            pc_d       = branch_target;
            fifo_flush = 1'b1;
            drop_d     = out_q - CW'(rsp_c);
        end else begin
            if (grant_c) pc_d = pc_q + 32'd4;
            if (rsp_c) begin
                if (drop_q != '0) drop_d = drop_q - CW'(1);
                else              fifo_push = 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            pc_q    <= RESET_PC;
            out_q   <= '0;
            drop_q  <= '0;
            aq_rd_q <= '0;
            aq_wr_q <= '0;
        end else begin
            pc_q    <= pc_d;
            out_q   <= out_d;
            drop_q  <= drop_d;
            aq_rd_q <= aq_rd_d;
            aq_wr_q <= aq_wr_d;
        end
    end

    // Address of each granted request, consumed in order by its response.
    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            for (int i = 0; i < int'(BUF_DEPTH); i++) aq_q[i] <= '0;
        end else if (grant_c) begin
            aq_q[aq_wr_q] <= pc_q;
        end
    end

    fetch_fifo #(
        .DEPTH (BUF_DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (res),
        .push_i  (fifo_push),
        .data_i  (fifo_wdata),
        .pop_i   (pop_c),
        .flush_i (fifo_flush),
        .head_o  (fifo_head),
        .count_o (fifo_cnt)
    );

    assign valid_out       = head_valid_c;
    assign instruction_out = head_valid_c ? fifo_head.instr : NOP_INSTR;
    assign PC_out          = fifo_head.pc;

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: streaming, decode stall, redirects, PC wrap, async reset.
module tb_fetch_unit;

    logic        clk;
    logic        res;
    logic        write;
    logic        branch_taken;
    logic [31:0] branch_target;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt;
    logic        imem_rvalid;
    logic [31:0] imem_rdata;
    logic [31:0] pc_out;
    logic [31:0] instr_out;
    logic        valid_out;

    logic        write2;
    logic        br2;
    logic [31:0] tgt2;
    logic        req2;
    logic [31:0] addr2;
    logic        gnt2;
    logic        rvalid2;
    logic [31:0] rdata2;
    logic [31:0] pc2;
    logic [31:0] instr2;
    logic        valid2;

    int          total;
    int          bad;
    bit          hold;
    logic [31:0] pend[$];
    logic [31:0] pend2[$];

    fetch_unit u_dut (
        .clk             (clk),
        .res             (res),
        .write           (write),
        .branch_taken    (branch_taken),
        .branch_target   (branch_target),
        .imem_req        (imem_req),
        .imem_addr       (imem_addr),
        .imem_gnt        (imem_gnt),
        .imem_rvalid     (imem_rvalid),
        .imem_rdata      (imem_rdata),
        .PC_out          (pc_out),
        .instruction_out (instr_out),
        .valid_out       (valid_out)
    );

    fetch_unit #(
        .RESET_PC (32'hFFFF_FFF8)
    ) u_wrap (
        .clk             (clk),
        .res             (res),
        .write           (write2),
        .branch_taken    (br2),
        .branch_target   (tgt2),
        .imem_req        (req2),
        .imem_addr       (addr2),
        .imem_gnt        (gnt2),
        .imem_rvalid     (rvalid2),
        .imem_rdata      (rdata2),
        .PC_out          (pc2),
        .instruction_out (instr2),
        .valid_out       (valid2)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] mdat(input logic [31:0] a);
        return a ^ 32'h1357_9BDF;
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic chk_head(input string tag, input logic v, input logic [31:0] pc,
                            input logic [31:0] ins, input logic [31:0] exp_pc);
        chk({tag, "_valid"}, 32'(v), 32'd1);
        chk({tag, "_pc"}, pc, exp_pc);
        chk({tag, "_instr"}, ins, mdat(exp_pc));
    endtask

    // Close the current cycle: record grants, then present next-cycle responses.
    task automatic adv();
        if (imem_req && imem_gnt) pend.push_back(imem_addr);
        if (req2 && gnt2) pend2.push_back(addr2);
        @(posedge clk);
        #1;
        if (!hold && pend.size() > 0) begin
            imem_rvalid = 1'b1;
            imem_rdata  = mdat(pend.pop_front());
        end else begin
            imem_rvalid = 1'b0;
            imem_rdata  = '0;
        end
        if (pend2.size() > 0) begin
            rvalid2 = 1'b1;
            rdata2  = mdat(pend2.pop_front());
        end else begin
            rvalid2 = 1'b0;
            rdata2  = '0;
        end
    endtask

    initial begin
        total = 0; bad = 0; hold = 1'b0;
        res = 1'b0; write = 1'b1; branch_taken = 1'b0; branch_target = '0;
        imem_gnt = 1'b1; imem_rvalid = 1'b0; imem_rdata = '0;
        write2 = 1'b1; br2 = 1'b0; tgt2 = '0; gnt2 = 1'b1; rvalid2 = 1'b0; rdata2 = '0;

        repeat (2) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", 32'(valid_out), 32'd0);
        chk("rst_instr", instr_out, 32'h0000_0013);
        chk("rst_req", 32'(imem_req), 32'd0);
        chk("rst_addr", imem_addr, 32'h0);
        chk("rst_addr2", addr2, 32'hFFFF_FFF8);
        @(posedge clk);
        #1 res = 1'b1;

        // Streaming from reset, plus the wrapping instance alongside
        @(negedge clk);
        chk("c0_req", 32'(imem_req), 32'd1);
        chk("c0_addr", imem_addr, 32'h0);
        chk("c0_valid", 32'(valid_out), 32'd0);
        chk("e0_addr", addr2, 32'hFFFF_FFF8);
        adv();
        @(negedge clk);
        chk("c1_addr", imem_addr, 32'h4);
        chk("c1_valid", 32'(valid_out), 32'd0);
        chk("e1_addr", addr2, 32'hFFFF_FFFC);
        adv();
        @(negedge clk);
        chk_head("c2", valid_out, pc_out, instr_out, 32'h0);
        chk("c2_addr", imem_addr, 32'h8);
        chk_head("e2", valid2, pc2, instr2, 32'hFFFF_FFF8);
        chk("e2_addr", addr2, 32'h0);
        adv();
        @(negedge clk);
        chk_head("c3", valid_out, pc_out, instr_out, 32'h4);
        chk_head("e3", valid2, pc2, instr2, 32'hFFFF_FFFC);
        adv();

        // Decode stall for four cycles
        write = 1'b0;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk_head("stall", valid_out, pc_out, instr_out, 32'h8);
            chk("stall_req", 32'(imem_req), 32'd0);
            if (i == 0) chk_head("e4", valid2, pc2, instr2, 32'h0);
            adv();
        end
        write = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            chk_head("resume", valid_out, pc_out, instr_out, 32'h8 + 32'(4 * i));
            if (i < 4) adv();
        end

        // Async reset pulse mid-stream
        #2 res = 1'b0;
        #1;
        chk("arst_valid", 32'(valid_out), 32'd0);
        chk("arst_instr", instr_out, 32'h0000_0013);
        chk("arst_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        pend.delete(); pend2.delete();
        imem_rvalid = 1'b0; rvalid2 = 1'b0;
        hold = 1'b1;
        res = 1'b1;

        // Redirect with two responses outstanding
        @(negedge clk);
        chk("d0_req", 32'(imem_req), 32'd1);
        chk("d0_addr", imem_addr, 32'h0);
        adv();
        @(negedge clk);
        chk("d1_addr", imem_addr, 32'h4);
        adv();
        @(negedge clk);
        chk("d2_req", 32'(imem_req), 32'd0);
        adv();
        branch_taken = 1'b1; branch_target = 32'h100;
        @(negedge clk);
        chk("d3_req", 32'(imem_req), 32'd0);
        hold = 1'b0;
        adv();
        branch_taken = 1'b0;
        @(negedge clk);
        chk("d4_req", 32'(imem_req), 32'd0);
        chk("d4_valid", 32'(valid_out), 32'd0);
        adv();
        @(negedge clk);
        chk("d5_req", 32'(imem_req), 32'd1);
        chk("d5_addr", imem_addr, 32'h100);
        chk("d5_valid", 32'(valid_out), 32'd0);
        adv();
        @(negedge clk);
        chk("d6_valid", 32'(valid_out), 32'd0);
        adv();
        @(negedge clk);
        chk_head("d7", valid_out, pc_out, instr_out, 32'h100);
        adv();

        // Redirect coincident with a response and write=1
        branch_taken = 1'b1; branch_target = 32'h100;
        @(negedge clk);
        chk("d8_rvalid", 32'(imem_rvalid), 32'd1);
        chk("d8_req", 32'(imem_req), 32'd0);
        chk_head("d8", valid_out, pc_out, instr_out, 32'h104);
        adv();
        branch_taken = 1'b0;
        imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
        @(negedge clk);
        chk("d9_req", 32'(imem_req), 32'd1);
        chk("d9_addr", imem_addr, 32'h100);
        chk("d9_valid", 32'(valid_out), 32'd0);
        adv();
        @(negedge clk);
        chk("d10_valid", 32'(valid_out), 32'd0);
        adv();
        @(negedge clk);
        chk_head("d11", valid_out, pc_out, instr_out, 32'h100);
        adv();
        @(negedge clk);
        chk_head("d12", valid_out, pc_out, instr_out, 32'h104);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
